// File: rtl/scr1_tb_imem_resp.sv
// Bench-side imem responder: preloadable memory answering fetches after LATENCY cycles.
// Optional `SCR1_TB_IMEM_STALL_EN adds LFSR-driven pseudo-random request stalls.
module scr1_tb_imem_resp #(
    parameter int          MEM_WORDS  = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0200,
    parameter int          LATENCY    = 2,
    parameter int          OUTSTD_MAX = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         imem_req,
    input  logic                         imem_cmd,
    input  logic [31:0]                  imem_addr,
    output logic                         imem_req_ack,
    output logic [31:0]                  imem_rdata,
    output logic [1:0]                   imem_resp,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_idx,
    input  logic [31:0]                  ld_data,
    output logic                         busy
);

    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] mem [MEM_WORDS];
    logic [3:0]  cnt_q;
    logic [1:0]  st_resp [LATENCY];
    logic [31:0] st_data [LATENCY];

    logic        stall;
    logic        accept;
    logic        resp_vld;
    logic [31:0] off;
    logic [29:0] idx_w;
    logic        err;
    logic [1:0]  new_resp;
    logic [31:0] new_data;

`ifdef SCR1_TB_IMEM_STALL_EN
    logic [15:0] lfsr_q;
    logic        lfsr_fb;

    // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
    assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign stall   = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
        end
    end
`else
    assign stall = 1'b0;
`endif

    assign imem_req_ack = rst_n & (cnt_q < 4'(OUTSTD_MAX)) & ~stall;
    assign accept       = imem_req & imem_req_ack;
    assign resp_vld     = |st_resp[LATENCY-1];

    assign off   = imem_addr - BASE_ADDR;
    assign idx_w = 30'(off >> 2);
    assign err   = imem_cmd
                 | (|imem_addr[1:0])
                 | (imem_addr < BASE_ADDR)
                 | ({2'b00, idx_w} >= 32'(MEM_WORDS));

    // Error responses carry zero data, so the pipe holds final output values
    assign new_resp = err ? 2'b10 : 2'b01;
    assign new_data = err ? 32'h0 : mem[idx_w[AW-1:0]];

    always_ff @(posedge clk) begin
        if (ld_en && (32'(ld_idx) < 32'(MEM_WORDS))) begin
            mem[ld_idx] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
            for (int i = 0; i < LATENCY; i++) begin
                st_resp[i] <= 2'b00;
                st_data[i] <= 32'h0;
            end
        end else begin
            cnt_q      <= cnt_q + 4'(accept) - 4'(resp_vld);
            st_resp[0] <= accept ? new_resp : 2'b00;
            st_data[0] <= accept ? new_data : 32'h0;
            for (int i = 1; i < LATENCY; i++) begin
                st_resp[i] <= st_resp[i-1];
                st_data[i] <= st_data[i-1];
            end
        end
    end

    assign imem_resp  = st_resp[LATENCY-1];
    assign imem_rdata = st_data[LATENCY-1];
    assign busy       = (cnt_q != 4'd0);

endmodule

// File: tb/tb_scr1_tb_imem_resp.sv
// Scoreboard bench for scr1_tb_imem_resp: cycle model predicts ack, resp, rdata, busy.
// Build with +define+SCR1_TB_IMEM_STALL_EN to also model the LFSR stalls.
module tb_scr1_tb_imem_resp;

    localparam int          LAT  = 2;
    localparam int          OMAX = 2;
    localparam int          MW   = 4096;
    localparam logic [31:0] BASE = 32'h0000_0200;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        imem_req;
    logic        imem_cmd;
    logic [31:0] imem_addr;
    logic        imem_req_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_resp;
    logic        ld_en;
    logic [11:0] ld_idx;
    logic [31:0] ld_data;
    logic        busy;

    always #5 clk = ~clk;

    scr1_tb_imem_resp #(
        .MEM_WORDS  (MW),
        .BASE_ADDR  (BASE),
        .LATENCY    (LAT),
        .OUTSTD_MAX (OMAX)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_cmd     (imem_cmd),
        .imem_addr    (imem_addr),
        .imem_req_ack (imem_req_ack),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .ld_en        (ld_en),
        .ld_idx       (ld_idx),
        .ld_data      (ld_data),
        .busy         (busy)
    );

    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    bit          chk_en = 0;
    int          mcount = 0;
    logic [15:0] mlfsr  = 16'hACE1;
    logic [1:0]  q_resp [$];
    logic [31:0] q_data [$];
    int          q_due  [$];
    logic [31:0] mm     [MW];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit stall_now();
`ifdef SCR1_TB_IMEM_STALL_EN
        return mlfsr[1:0] == 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit ack_now();
        return (mcount < OMAX) && !stall_now();
    endfunction

    // One clock cycle: drive, check at negedge, advance model, cross posedge
    task automatic step(input logic rst, input logic req, input logic cmd,
                        input logic [31:0] addr, input logic le,
                        input logic [11:0] li, input logic [31:0] ld,
                        output logic acked);
        logic        m_ack;
        logic        due;
        logic        e;
        logic [31:0] off;
        logic [1:0]  er;
        logic [31:0] ed;
        rst_n = rst; imem_req = req; imem_cmd = cmd; imem_addr = addr;
        ld_en = le; ld_idx = li; ld_data = ld;
        @(negedge clk);
        m_ack = rst && ack_now();
        due   = (q_due.size() > 0) && (q_due[0] == cyc);
        er    = due ? q_resp[0] : 2'b00;
        ed    = due ? q_data[0] : 32'h0;
        if (chk_en) begin
            check("ack",   32'(imem_req_ack), 32'(m_ack));
            check("resp",  32'(imem_resp),    32'(er));
            check("rdata", imem_rdata,        ed);
            check("busy",  32'(busy),         32'(mcount != 0));
        end
        if (due) begin
            void'(q_resp.pop_front());
            void'(q_data.pop_front());
            void'(q_due.pop_front());
        end
        acked = req && m_ack;
        if (!rst) begin
            q_resp.delete(); q_data.delete(); q_due.delete();
            mcount = 0;
            mlfsr  = 16'hACE1;
        end else begin
            if (acked) begin
                off = addr - BASE;
                e = cmd || (addr[1:0] != 2'b00) || (addr < BASE) ||
                    ((off >> 2) >= MW);
                q_resp.push_back(e ? 2'b10 : 2'b01);
                q_data.push_back(e ? 32'h0 : mm[int'(off >> 2)]);
                q_due.push_back(cyc + LAT);
                mcount++;
            end
            if (due) mcount--;
            mlfsr = {mlfsr[0] ^ mlfsr[2] ^ mlfsr[3] ^ mlfsr[5], mlfsr[15:1]};
        end
        if (le) mm[li] = ld;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        logic a;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0, a);
    endtask

    task automatic preload(input logic [11:0] i, input logic [31:0] d);
        logic a;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, i, d, a);
    endtask

    task automatic fetch(input logic [31:0] addr, input logic cmd);
        logic a;
        int   k;
        a = 1'b0;
        for (k = 0; k < 50 && !a; k++) step(1'b1, 1'b1, cmd, addr, 1'b0, 12'h0, 32'h0, a);
        if (!a) check("ack_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && (q_due.size() > 0 || mcount != 0); k++) idle();
        check("drained", 32'(q_due.size()), 32'd0);
        check("count0",  32'(mcount),       32'd0);
        idle();
    endtask

    initial begin
        logic a;
        int   k;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0, a);
        chk_en = 1;
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0, a);

        preload(12'd0, 32'h0000_006F);
        preload(12'd1, 32'h1111_0001);
        preload(12'd2, 32'h2222_0002);
        preload(12'd3, 32'h3333_0003);

        fetch(32'h200, 1'b0);
        drain();

        fetch(32'h200, 1'b0);
        fetch(32'h204, 1'b0);
        fetch(32'h208, 1'b0);
        fetch(32'h20C, 1'b0);
        drain();

        fetch(32'h202, 1'b0);
        fetch(32'h1FC, 1'b0);
        fetch(BASE + 32'(4 * MW), 1'b0);
        fetch(32'h204, 1'b1);
        drain();

        fetch(32'h200, 1'b0);
        fetch(32'h204, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 12'h0, 32'h0, a);
        for (int i = 0; i < 4; i++) idle();
        check("mem0_model", mm[0], 32'h0000_006F);
        fetch(32'h200, 1'b0);
        drain();

        for (k = 0; k < 20 && !ack_now(); k++) idle();
        a = 1'b0;
        for (k = 0; k < 50 && !a; k++)
            step(1'b1, 1'b1, 1'b0, 32'h200, 1'b1, 12'd0, 32'hDEAD_BEEF, a);
        fetch(32'h200, 1'b0);
        drain();

        for (int i = 0; i < 64; i++) preload(12'(i), $urandom);
        for (int i = 0; i < 1000; i++) begin
            if (i % 97 == 50) fetch(32'h1F0, 1'b0);
            else fetch(BASE + 32'(4 * (i % 64)), 1'b0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
